dram_uart_transmitter: RTL and testbench
========================================

// Module: dram_uart_transmitter
// PURPOSE
//  Streams a block of DRAM bytes out of a UART Tx pin once the processor signals completion.
//  The DRAM receiver side loads DRAM and holds the processor off; this block reverses that.
//  It sits between Processor.start_Tx, the DRAM address/read-data mux, and the board Tx pin.
//  Frame format: 8N1, LSB first, idle high.
// PARAMETERS
//  CLKS_PER_BIT  434     clk cycles per UART bit (50 MHz / 115200); legal range >= 2
//  START_ADDR    16'h0   first DRAM address sent
//  NUM_BYTES     256     bytes per transfer; legal range 1..65536
//  READ_LAT      2       clocks from DRAM_address register update to valid DRAM_read_data
// PORTS
//  clk             in   1   system clock; all logic on its rising edge
//  reset           in   1   synchronous, active-high reset
//  start_Tx        in   1   level from Processor; a 0->1 transition starts one transfer
//  DRAM_address    out  16  registered read address to the DRAM address mux
//  DRAM_read_data  in   8   DRAM q
//  Tx              out  1   UART serial out, registered
//  tx_busy         out  1   high from the cycle after the start edge until the done pulse
//  tx_done         out  1   one-cycle pulse after the last stop bit completes
// BEHAVIOUR
//  - Reset values: Tx=1, tx_busy=0, tx_done=0, DRAM_address=START_ADDR, state=IDLE, start_q=1.
//    start_q=1 means a start_Tx already high at reset does not trigger a transfer.
//  - Start edge = start_Tx & ~start_q, where start_q is start_Tx registered every cycle.
//    - Edges are ignored outside IDLE.
//    - Holding start_Tx high never retriggers; it must fall, then rise again.
//  - FSM states: IDLE, FETCH, START, DATA, STOP, DONE.
//    - IDLE -> FETCH on edge. Load byte_cnt=NUM_BYTES-1, DRAM_address=START_ADDR, tx_busy=1.
//    - FETCH waits READ_LAT cycles, then captures DRAM_read_data into shreg -> START.
//    - START drives Tx=0 for CLKS_PER_BIT cycles -> DATA.
//    - DATA drives Tx=shreg[0]. It shifts right every CLKS_PER_BIT cycles, for exactly 8 bits -> STOP.
//    - STOP drives Tx=1 for CLKS_PER_BIT cycles.
//      - If byte_cnt==0 -> DONE.
//      - Otherwise decrement byte_cnt, increment DRAM_address, -> FETCH.
//    - DONE asserts tx_done for 1 cycle and drops tx_busy in the same cycle -> IDLE.
//  - Tx stays 1 during FETCH. The inter-byte gap is READ_LAT+1 idle-high cycles (extended stop).
//  - DRAM_address increments modulo 2^16; START_ADDR+NUM_BYTES > 65536 wraps to 16'h0000.
//  - Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, clears on every state change.
//  - byte_cnt: 16 bits (NUM_BYTES-1 always fits). bit_cnt: 3 bits.
//  - reset mid-frame: the next edge forces all reset values (Tx=1 at once). No partial byte resumes.
//  - Block never writes DRAM; the write-enable mux stays owned by the processor/receiver.
//  - Frame time per byte = 10*CLKS_PER_BIT + READ_LAT + 1 clocks.
// STRUCTURE
//  - Shared include uart_defs.vh: default CLKS_PER_BIT, 8N1 frame constants, FSM state encodings.
//  - Natural sub-module: uart_tx_serializer (byte + valid in, ready out, Tx out; START/DATA/STOP).
//    - Top keeps IDLE/FETCH/DONE, address and byte counters, and the start edge detect.
//    - Handshake: valid&ready for one cycle loads the byte; ready returns high the cycle after STOP ends.
// TESTING (sim with CLKS_PER_BIT=4, READ_LAT=2)
//  1. DRAM[0..2]=8'hA5,8'h3C,8'hFF, NUM_BYTES=3, start_Tx 0->1.
//     Tx bits 0,1,0,1,0,0,1,0,1,1 then 3C, FF frames; each bit exactly 4 clocks.
//     tx_done pulses once; DRAM_address ends 16'h0002.
//  2. start_Tx held high 2000 clocks after done -> no second transfer.
//     Then toggle 0->1 -> transfer repeats from START_ADDR.
//  3. Second start_Tx edge while tx_busy -> ignored: byte count and Tx stream identical to test 1.
//  4. reset asserted during bit 4 of byte 1 -> next cycle Tx=1, tx_busy=0, DRAM_address=START_ADDR.
//     A fresh edge restarts at byte 0.
//  5. START_ADDR=16'hFFFF, NUM_BYTES=2 -> addresses FFFF then 0000 are read and sent.
//  6. NUM_BYTES=1, start_Tx already high at reset release -> no transfer until it falls and rises.
//     Then exactly 1 frame, tx_busy high for 10*4+3+1 cycles.

Source files
------------

// File: rtl/dram_uart_transmitter_pkg.sv
// Shared definitions for the DRAM-to-UART transmitter: 8N1 frame constants
// and the state encodings of the controller and the serializer.
package dram_uart_transmitter_pkg;

  localparam int   DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200
  localparam int   FRAME_DATA_BITS      = 8;
  localparam logic TX_IDLE_LEVEL        = 1'b1;
  localparam logic START_BIT_LEVEL      = 1'b0;
  localparam logic STOP_BIT_LEVEL       = 1'b1;

  // Controller: IDLE waits for the start edge, FETCH waits out the DRAM read
  // latency, SEND waits for the serializer to finish the frame, DONE pulses.
  typedef enum logic [1:0] {
    CTL_IDLE,
    CTL_FETCH,
    CTL_SEND,
    CTL_DONE
  } ctl_state_t;

  // Serializer: IDLE (ready), START bit, DATA bits LSB first, STOP bit.
  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

endpackage

// File: rtl/dram_uart_transmitter_serializer.sv
// 8N1 UART serializer. A byte is accepted on valid while ready; ready returns
// the cycle after the stop bit ends. Tx is registered and idles high.
module dram_uart_transmitter_serializer
  import dram_uart_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(FRAME_DATA_BITS - 1);

  ser_state_t        r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_shreg, w_shreg_nxt;
  logic              r_tx, w_tx_nxt;
  logic              w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);
  assign o_ready    = (r_state == SER_IDLE);
  assign o_tx       = r_tx;

  // Next state, shift register, bit/baud counters and the Tx level of the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit;
    case (r_state)
      SER_IDLE: begin
        if (i_valid) begin
          w_state_nxt = SER_START;
          w_shreg_nxt = i_data;
        end
      end
      SER_START: begin
        if (w_baud_end) begin
          w_state_nxt = SER_DATA;
          w_bit_nxt   = '0;
        end
      end
      SER_DATA: begin
        if (w_baud_end) begin
          if (r_bit == BIT_LAST) begin
            w_state_nxt = SER_STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shreg_nxt = {1'b0, r_shreg[7:1]};
          end
        end
      end
      SER_STOP: begin
        if (w_baud_end) w_state_nxt = SER_IDLE;
      end
      default: w_state_nxt = SER_IDLE;
    endcase

    // Baud counter restarts on every state change and at each bit boundary.
    if ((w_state_nxt != r_state) || (r_state == SER_IDLE) || w_baud_end) begin
      w_baud_nxt = '0;
    end else begin
      w_baud_nxt = r_baud + BAUD_W'(1);
    end

    case (w_state_nxt)
      SER_START: w_tx_nxt = START_BIT_LEVEL;
      SER_DATA:  w_tx_nxt = w_shreg_nxt[0];
      SER_STOP:  w_tx_nxt = STOP_BIT_LEVEL;
      default:   w_tx_nxt = TX_IDLE_LEVEL;
    endcase
  end

  // Serializer state register; reset forces the line idle immediately.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SER_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= TX_IDLE_LEVEL;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

endmodule

// File: rtl/dram_uart_transmitter.sv
// Streams NUM_BYTES DRAM bytes starting at START_ADDR out of the UART Tx pin
// after a rising edge on i_start_tx. Owns start-edge detect, DRAM addressing,
// the byte counter and the busy/done handshake; framing is in the serializer.
//
// The address of the next byte is advanced when the current byte is handed to
// the serializer, so its read data is long valid when the frame ends. The cycle
// in which the serializer reports ready again counts as the first fetch cycle,
// which keeps every byte at 10*CLKS_PER_BIT + READ_LAT + 1 clocks.
module dram_uart_transmitter
  import dram_uart_transmitter_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter int          NUM_BYTES    = 256,
  parameter int          READ_LAT     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_tx,
  output logic [15:0] o_dram_address,
  input  logic [7:0]  i_dram_read_data,
  output logic        o_tx,
  output logic        o_tx_busy,
  output logic        o_tx_done
);

  localparam logic [15:0] BYTE_CNT_INIT = 16'(NUM_BYTES - 1);
  localparam logic [7:0]  LAT_LAST      = 8'(READ_LAT);
  localparam logic [7:0]  LAT_RESUME    = (READ_LAT > 0) ? 8'd1 : 8'd0;

  ctl_state_t  r_state, w_state_nxt;
  logic        r_start_q;
  logic [15:0] r_addr;
  logic [15:0] r_byte_cnt;
  logic [7:0]  r_lat_cnt;
  logic        w_start_edge;
  logic        w_lat_done;
  logic        w_last_byte;
  logic        w_ser_valid;
  logic        w_ser_ready;

  assign w_start_edge   = i_start_tx & ~r_start_q;
  assign w_lat_done     = (r_lat_cnt == LAT_LAST);
  assign w_last_byte    = (r_byte_cnt == 16'd0);
  assign o_dram_address = r_addr;
  assign o_tx_busy      = (r_state == CTL_FETCH) || (r_state == CTL_SEND);
  assign o_tx_done      = (r_state == CTL_DONE);

  // Controller next state and the serializer load strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_ser_valid = 1'b0;
    case (r_state)
      CTL_IDLE: begin
        if (w_start_edge) w_state_nxt = CTL_FETCH;
      end
      CTL_FETCH: begin
        if (w_lat_done) begin
          w_ser_valid = 1'b1;
          if (w_ser_ready) w_state_nxt = CTL_SEND;
        end
      end
      CTL_SEND: begin
        if (w_ser_ready) w_state_nxt = w_last_byte ? CTL_DONE : CTL_FETCH;
      end
      CTL_DONE: w_state_nxt = CTL_IDLE;
      default:  w_state_nxt = CTL_IDLE;
    endcase
  end

  // Controller state register and start-level history.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= CTL_IDLE;
      r_start_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= i_start_tx;
    end
  end

  // Address, byte counter and read-latency counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= START_ADDR;
      r_byte_cnt <= '0;
      r_lat_cnt  <= '0;
    end else begin
      case (r_state)
        CTL_IDLE: begin
          if (w_start_edge) begin
            r_addr     <= START_ADDR;
            r_byte_cnt <= BYTE_CNT_INIT;
            r_lat_cnt  <= '0;
          end
        end
        CTL_FETCH: begin
          if (!w_lat_done) begin
            r_lat_cnt <= r_lat_cnt + 8'd1;
          end else if (w_ser_ready && !w_last_byte) begin
            r_addr <= r_addr + 16'd1;
          end
        end
        CTL_SEND: begin
          if (w_ser_ready && !w_last_byte) begin
            r_byte_cnt <= r_byte_cnt - 16'd1;
            r_lat_cnt  <= LAT_RESUME;
          end
        end
        default: ;
      endcase
    end
  end

  dram_uart_transmitter_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_data  (i_dram_read_data),
    .i_valid (w_ser_valid),
    .o_ready (w_ser_ready),
    .o_tx    (o_tx)
  );

endmodule

// File: tb/tb_dram_uart_transmitter.sv
// Bench for dram_uart_transmitter: three instances (plain, address wrap,
// single byte) share one DRAM image; expected Tx/busy/done per cycle come
// from a frame-timing model computed from the transfer arithmetic.
module tb_dram_uart_transmitter;

  localparam int C  = 4;
  localparam int R  = 2;
  localparam int F  = R + 1;            // fetch cycles before the first start bit
  localparam int P  = 10 * C + R + 1;   // clocks per byte
  localparam logic [15:0] SA0 = 16'h0000;
  localparam logic [15:0] SA1 = 16'hFFFF;
  localparam logic [15:0] SA2 = 16'h0010;
  localparam int NB0 = 3;
  localparam int NB1 = 2;
  localparam int NB2 = 1;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        start [3];
  logic [15:0] addr  [3];
  logic [7:0]  rdata [3];
  logic [7:0]  rq1   [3];
  logic        tx    [3];
  logic        busy  [3];
  logic        done  [3];
  logic [7:0]  mem   [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dram_uart_transmitter #(.CLKS_PER_BIT(C), .START_ADDR(SA0), .NUM_BYTES(NB0), .READ_LAT(R)) u_dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_start_tx(start[0]), .o_dram_address(addr[0]),
    .i_dram_read_data(rdata[0]), .o_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));

  dram_uart_transmitter #(.CLKS_PER_BIT(C), .START_ADDR(SA1), .NUM_BYTES(NB1), .READ_LAT(R)) u_dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_start_tx(start[1]), .o_dram_address(addr[1]),
    .i_dram_read_data(rdata[1]), .o_tx(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));

  dram_uart_transmitter #(.CLKS_PER_BIT(C), .START_ADDR(SA2), .NUM_BYTES(NB2), .READ_LAT(R)) u_dut2 (
    .i_clk(clk), .i_reset(rst[2]), .i_start_tx(start[2]), .o_dram_address(addr[2]),
    .i_dram_read_data(rdata[2]), .o_tx(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

  // DRAM read port model: data valid READ_LAT clocks after the address changes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rq1[i]   <= mem[addr[i]];
      rdata[i] <= rq1[i];
    end
  end

  function automatic logic [15:0] sa_of(input int sel);
    case (sel)
      0:       return SA0;
      1:       return SA1;
      default: return SA2;
    endcase
  endfunction

  function automatic int nb_of(input int sel);
    case (sel)
      0:       return NB0;
      1:       return NB1;
      default: return NB2;
    endcase
  endfunction

  // Clock index (counted from the start edge) at which tx_done is high.
  function automatic int n_done(input int nb);
    return F + (nb - 1) * P + 10 * C + 2;
  endfunction

  // Expected Tx level n clocks after the start edge.
  function automatic logic exp_tx(input int n, input logic [15:0] sa, input int nb);
    int o, k, b;
    logic [15:0] a;
    logic [7:0]  d;
    if (n <= F) return 1'b1;
    o = n - (F + 1);
    k = o / P;
    o = o % P;
    if (k >= nb) return 1'b1;
    if (o >= 10 * C) return 1'b1;
    b = o / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    a = sa + 16'(k);
    d = mem[a];
    return d[b - 1];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_bytes(input int sel);
    logic [15:0] a;
    for (int k = 0; k < nb_of(sel); k++) begin
      a = sa_of(sel) + 16'(k);
      mem[a] = 8'($urandom_range(0, 255));
    end
  endtask

  // Full transfer on one instance with per-cycle checks; optional retrigger attempt.
  task automatic run_transfer(input int sel, input bit glitch, output int busy_cycles, output int done_pulses);
    int nd;
    logic etx;
    nd = n_done(nb_of(sel));
    start[sel] = 1'b0;
    tick();
    tick();
    start[sel] = 1'b1;
    busy_cycles = 0;
    done_pulses = 0;
    for (int n = 1; n <= nd + 2; n++) begin
      tick();
      etx = exp_tx(n, sa_of(sel), nb_of(sel));
      n_checks++;
      if (tx[sel] !== etx)
        $display("FAIL tx dut%0d n=%0d: got %b expected %b", sel, n, tx[sel], etx);
      if (tx[sel] !== etx) n_fail++;
      n_checks++;
      if (busy[sel] !== (n < nd)) begin
        $display("FAIL busy dut%0d n=%0d: got %b expected %b", sel, n, busy[sel], (n < nd));
        n_fail++;
      end
      n_checks++;
      if (done[sel] !== (n == nd)) begin
        $display("FAIL done dut%0d n=%0d: got %b expected %b", sel, n, done[sel], (n == nd));
        n_fail++;
      end
      if (busy[sel] === 1'b1) busy_cycles++;
      if (done[sel] === 1'b1) done_pulses++;
      if (glitch && n == 10) start[sel] = 1'b0;
      if (glitch && n == 20) start[sel] = 1'b1;
    end
  endtask

  task automatic check_end(input int sel, input int bc, input int dp, input logic [15:0] exp_addr, input int exp_busy);
    n_checks++;
    if (dp !== 1) begin
      $display("FAIL done_count dut%0d: got %0d expected 1", sel, dp);
      n_fail++;
    end
    n_checks++;
    if (bc !== exp_busy) begin
      $display("FAIL busy_cycles dut%0d: got %0d expected %0d", sel, bc, exp_busy);
      n_fail++;
    end
    n_checks++;
    if (addr[sel] !== exp_addr) begin
      $display("FAIL final_addr dut%0d: got %h expected %h", sel, addr[sel], exp_addr);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst[i]   = 1'b1;
      start[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || addr[i] !== sa_of(i)) begin
        $display("FAIL reset dut%0d: got tx=%b busy=%b done=%b addr=%h expected tx=1 busy=0 done=0 addr=%h",
                 i, tx[i], busy[i], done[i], addr[i], sa_of(i));
        n_fail++;
      end
      rst[i] = 1'b0;
    end
    tick();
  endtask

  task automatic test_basic();
    int bc, dp;
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    mem[2] = 8'hFF;
    run_transfer(0, 1'b0, bc, dp);
    check_end(0, bc, dp, 16'h0002, n_done(NB0) - 1);
    randomize_bytes(0);
    run_transfer(0, 1'b0, bc, dp);
    check_end(0, bc, dp, 16'h0002, n_done(NB0) - 1);
  endtask

  task automatic test_hold_high();
    int bc, dp;
    for (int n = 0; n < 2000; n++) begin
      tick();
      n_checks++;
      if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
        $display("FAIL hold_high n=%0d: got busy=%b tx=%b expected busy=0 tx=1", n, busy[0], tx[0]);
        n_fail++;
      end
    end
    randomize_bytes(0);
    run_transfer(0, 1'b0, bc, dp);
    check_end(0, bc, dp, 16'h0002, n_done(NB0) - 1);
  endtask

  task automatic test_back_to_back();
    int bc, dp;
    randomize_bytes(0);
    run_transfer(0, 1'b1, bc, dp);
    check_end(0, bc, dp, 16'h0002, n_done(NB0) - 1);
  endtask

  task automatic test_reset_mid();
    int bc, dp;
    int abort_n;
    logic etx;
    abort_n = F + 1 + P + 5 * C + 1;   // middle of data bit 4 of byte 1
    randomize_bytes(0);
    start[0] = 1'b0;
    tick();
    tick();
    start[0] = 1'b1;
    for (int n = 1; n <= abort_n; n++) begin
      tick();
      etx = exp_tx(n, SA0, NB0);
      n_checks++;
      if (tx[0] !== etx) begin
        $display("FAIL mid_tx n=%0d: got %b expected %b", n, tx[0], etx);
        n_fail++;
      end
    end
    rst[0] = 1'b1;
    tick();
    n_checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || addr[0] !== SA0) begin
      $display("FAIL mid_reset: got tx=%b busy=%b done=%b addr=%h expected tx=1 busy=0 done=0 addr=%h",
               tx[0], busy[0], done[0], addr[0], SA0);
      n_fail++;
    end
    rst[0] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      n_checks++;
      if (busy[0] !== 1'b0) begin
        $display("FAIL post_reset_idle n=%0d: got busy=%b expected 0", n, busy[0]);
        n_fail++;
      end
    end
    run_transfer(0, 1'b0, bc, dp);
    check_end(0, bc, dp, 16'h0002, n_done(NB0) - 1);
  endtask

  task automatic test_wrap();
    int bc, dp;
    randomize_bytes(1);
    run_transfer(1, 1'b0, bc, dp);
    check_end(1, bc, dp, 16'h0000, n_done(NB1) - 1);
  endtask

  task automatic test_single();
    int bc, dp;
    randomize_bytes(2);
    rst[2]   = 1'b1;
    start[2] = 1'b1;
    tick();
    tick();
    rst[2] = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      n_checks++;
      if (busy[2] !== 1'b0 || tx[2] !== 1'b1) begin
        $display("FAIL high_at_reset n=%0d: got busy=%b tx=%b expected busy=0 tx=1", n, busy[2], tx[2]);
        n_fail++;
      end
    end
    run_transfer(2, 1'b0, bc, dp);
    check_end(2, bc, dp, SA2, 10 * 4 + 3 + 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      rst[i]   = 1'b1;
      start[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold_high();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
